// File: rtl/lg_pkg.sv
// rtl/lg_pkg.sv - gate op encodings, op type and identity helpers for the gate array
package lg_pkg;

  localparam int OP_W = 3;

  typedef enum logic [1:0] {
    GATE_AND  = 2'b00,
    GATE_OR   = 2'b01,
    GATE_XOR  = 2'b10,
    GATE_ZERO = 2'b11
  } gate_fn_e;

  // Bit 2 inverts the reduced result; bits 1:0 pick the reduction.
  typedef struct packed {
    logic     inv;
    gate_fn_e fn;
  } gate_op_t;

  localparam gate_op_t OP_RESET = '{inv: 1'b0, fn: GATE_AND};

  // Value a reduction yields over an empty operand set.
  function automatic logic identity_value(input gate_fn_e fn);
    return (fn == GATE_AND);
  endfunction

  // Channel k powers up as an AND over its lowest min(k+2, n_in) inputs.
  function automatic logic [15:0] default_mask(input int k, input int n_in);
    int w;
    w = (k + 2 < n_in) ? k + 2 : n_in;
    return 16'((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/lg_gate_eval.sv
// rtl/lg_gate_eval.sv - combinational masked AND/OR/XOR reduction with optional invert
module lg_gate_eval
  import lg_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic [N_IN-1:0] data,
  input  logic [N_IN-1:0] mask,
  input  gate_op_t        op,
  output logic            y
);

  logic acc;

  always_comb begin
    acc = identity_value(op.fn);
    for (int i = 0; i < N_IN; i++) begin
      if (mask[i]) begin
        case (op.fn)
          GATE_AND: acc = acc & data[i];
          GATE_OR:  acc = acc | data[i];
          GATE_XOR: acc = acc ^ data[i];
          default:  acc = 1'b0;
        endcase
      end
    end
    y = acc ^ op.inv;
  end

endmodule

// File: rtl/lg_gate_array.sv
// rtl/lg_gate_array.sv - configurable multi-channel gate array with 2-entry result FIFO
module lg_gate_array
  import lg_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int CHANNELS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_ch,
  input  logic [OP_W-1:0]     cfg_op,
  input  logic [N_IN-1:0]     cfg_mask,
  output logic                cfg_err,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_IN-1:0]     in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CHANNELS-1:0] out_y
);

  localparam logic [3:0] CH_LIMIT = 4'(CHANNELS);

  logic                cfg_hit;
  logic [CHANNELS-1:0] y_eval;

  assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);

  // Evaluation reads the registered config, so a same-cycle write only affects later vectors.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam logic [15:0] DEF_MASK = default_mask(k, N_IN);

    gate_op_t        op_q;
    logic [N_IN-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        op_q   <= OP_RESET;
        mask_q <= DEF_MASK[N_IN-1:0];
      end else if (cfg_hit && (cfg_ch == 3'(k))) begin
        op_q   <= gate_op_t'(cfg_op);
        mask_q <= cfg_mask;
      end
    end

    lg_gate_eval #(.N_IN(N_IN)) u_eval (
      .data (in_data),
      .mask (mask_q),
      .op   (op_q),
      .y    (y_eval[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && ({1'b0, cfg_ch} >= CH_LIMIT);
    end
  end

  logic [CHANNELS-1:0] fifo_mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;
  logic                push;
  logic                pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_y     = fifo_mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Entries are cleared on reset so out_y reads zero until a result is stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= y_eval;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/lg_gate_array.md
LG_GATE_ARRAY -- requirements
Module: lg_gate_array

Interface
REQ-001 SHALL have parameter N_IN, default 4, inputs per vector (2..16).
REQ-002 SHALL have parameter CHANNELS, default 3, independent gate channels (1..8).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_we  input  1  config write strobe.
REQ-006 SHALL have port cfg_ch  input  3  channel index for write.
REQ-007 SHALL have port cfg_op  input  3  gate op: [1:0] 00 AND, 01 OR, 10 XOR, 11 const-0; [2] invert result.
REQ-008 SHALL have port cfg_mask  input  N_IN  fan-in enable, bit i selects in_data[i].
REQ-009 SHALL have port cfg_err  output  1  one-cycle pulse, rejected config write.
REQ-010 SHALL have port in_valid  input  1  input vector valid.
REQ-011 SHALL have port in_ready  output  1  block can accept vector.
REQ-012 SHALL have port in_data  input  N_IN  input vector (A,B,C,D,... = bit 0,1,2,3,...).
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port out_y  output  CHANNELS  per-channel result, bit k = channel k.

Function
REQ-016 SHALL transfer input when in_valid & in_ready at rising clk; output when out_valid & out_ready.
REQ-017 SHALL evaluate channel k as op over in_data bits whose cfg mask bit is 1, then invert if op[2].
REQ-018 SHALL use empty-set identity when mask is all zero: AND 1, OR 0, XOR 0, const 0; invert still applies.
REQ-019 SHALL evaluate all channels of a vector with the config held in the cycle it is accepted; a cfg write in the same cycle affects only later vectors.
REQ-020 SHALL store results in a 2-entry FIFO; output = head entry; latency accept-to-out_valid = 1 cycle when FIFO empty.
REQ-021 SHALL drive in_ready = (FIFO count < 2), registered-count based, no combinational path from out_ready.
REQ-022 SHALL on simultaneous push and pop with count 1 keep count 1 and present new entry next cycle.
REQ-023 SHALL hold out_y stable while out_valid & !out_ready.
REQ-024 SHALL ignore a cfg write with cfg_ch >= CHANNELS, leave all config unchanged, pulse cfg_err next cycle.
REQ-025 SHALL accept a valid cfg write every cycle; back-to-back writes to one channel: last wins.

Reset
REQ-026 SHALL on rst_n low immediately clear FIFO count, out_valid 0, cfg_err 0, out_y 0; in_ready 1 after release.
REQ-027 SHALL reset channel k config to op AND (000), mask = lowest min(k+2, N_IN) bits set (2-, 3-, 4-input AND at defaults).
REQ-028 SHALL discard FIFO contents on reset mid-operation; no result emitted for pre-reset vectors.

Structure
REQ-029 SHALL place op encoding constants, op width, and identity-value function in package lg_pkg.
REQ-030 SHALL implement per-channel reduction as sub-module lg_gate_eval (combinational: data, mask, op -> y), instantiated CHANNELS times.
REQ-031 SHALL keep config registers, FIFO and handshake in lg_gate_array top.

Verification
REQ-032 Reset defaults, out_ready 1: vectors 0011, 0111, 1111 (D..A) -> out_y 001, 011, 111 each one cycle after accept.
REQ-033 Config ch0 op 101 (NOR) mask 1111 then ch0 mask 0000 op 100: vector 0000 -> y0 1, then any vector -> y0 0 (NAND of empty = 0).
REQ-034 out_ready 0, push 3 vectors -> in_ready drops after 2 accepts; release out_ready -> results in order, none lost.
REQ-035 cfg write ch1 op 010 same cycle as vector 0110 accepted -> that result uses AND 3-input (y1 0); next 0110 -> y1 0 XOR of bits 0..2 = 0, 0111 -> y1 1.
REQ-036 cfg_ch 5 with CHANNELS 3 -> cfg_err pulse 1 cycle, outputs for next vector unchanged from defaults.
REQ-037 rst_n low with 2 entries stored -> out_valid 0 asynchronously, no stale result after release.
